// File: rtl/pc_unit.sv
// pc_unit -- parametrised fetch-stage program counter.
//
// Generates the instruction fetch address. On every cycle it can advance
// sequentially, take a jump or branch redirect, or take the exception
// vector. It can also hold for a hazard stall. If a jump or branch arrives
// while the PC is stalled, it is kept in a one-entry pending buffer and
// applied once the stall releases.
//
// Ports:
//   i_clk            clock, all state updates on rising edge
//   i_rst            synchronous reset, active-high
//   i_stall          hold current address
//   i_jump_en        jump redirect request (wins over branch)
//   i_jump_target    jump target
//   i_branch_en      taken-branch redirect request
//   i_branch_target  branch target
//   i_exc            exception request (highest priority, ignores stall)
//   o_address        current fetch address, low ALIGN bits always zero
//   o_next_seq       o_address + 2**ALIGN, for the link register
//   o_epc            o_address captured when the last exception was taken
//   o_redirect       o_address holds a non-sequential value this cycle
//   o_misaligned     a loaded jump/branch/pending target had low bits set
module pc_unit #(
    parameter int unsigned       WIDTH      = 32,
    parameter int unsigned       ALIGN      = 2,
    parameter logic [WIDTH-1:0]  RESET_ADDR = 32'h0000_0000,
    parameter logic [WIDTH-1:0]  EXC_ADDR   = 32'h8000_0180
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_stall,
    input  logic             i_jump_en,
    input  logic [WIDTH-1:0] i_jump_target,
    input  logic             i_branch_en,
    input  logic [WIDTH-1:0] i_branch_target,
    input  logic             i_exc,
    output logic [WIDTH-1:0] o_address,
    output logic [WIDTH-1:0] o_next_seq,
    output logic [WIDTH-1:0] o_epc,
    output logic             o_redirect,
    output logic             o_misaligned
);

    localparam logic [WIDTH-1:0] INC        = WIDTH'(1) << ALIGN;
    localparam logic [WIDTH-1:0] LOW_MASK   = INC - WIDTH'(1);
    localparam logic [WIDTH-1:0] RESET_VEC  = RESET_ADDR & ~LOW_MASK;
    localparam logic [WIDTH-1:0] EXC_VEC    = EXC_ADDR & ~LOW_MASK;

    logic             req;
    logic [WIDTH-1:0] sel_t;

    // pend_addr keeps the raw target so misalignment is judged at load time
    logic             pend_vld,  pend_vld_nxt;
    logic [WIDTH-1:0] pend_addr, pend_addr_nxt;

    logic [WIDTH-1:0] address_nxt;
    logic [WIDTH-1:0] epc_nxt;
    logic             redirect_nxt;
    logic             misaligned_nxt;

    assign req        = i_jump_en | i_branch_en;
    assign sel_t      = i_jump_en ? i_jump_target : i_branch_target;
    assign o_next_seq = o_address + INC;

    always_comb begin
        address_nxt    = o_address;
        epc_nxt        = o_epc;
        redirect_nxt   = 1'b0;
        misaligned_nxt = 1'b0;
        pend_vld_nxt   = pend_vld;
        pend_addr_nxt  = pend_addr;

        if (i_exc) begin
            // exception drops both the pending entry and any same-cycle request
            address_nxt  = EXC_VEC;
            epc_nxt      = o_address;
            pend_vld_nxt = 1'b0;
            redirect_nxt = 1'b1;
        end else if (i_stall) begin
            if (req) begin
                pend_vld_nxt  = 1'b1;
                pend_addr_nxt = sel_t;
            end
        end else if (req) begin
            // a live request supersedes a stale pending one
            address_nxt    = sel_t & ~LOW_MASK;
            redirect_nxt   = 1'b1;
            misaligned_nxt = |(sel_t & LOW_MASK);
            pend_vld_nxt   = 1'b0;
        end else if (pend_vld) begin
            address_nxt    = pend_addr & ~LOW_MASK;
            redirect_nxt   = 1'b1;
            misaligned_nxt = |(pend_addr & LOW_MASK);
            pend_vld_nxt   = 1'b0;
        end else begin
            address_nxt = o_address + INC;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_address    <= RESET_VEC;
            o_epc        <= '0;
            o_redirect   <= 1'b0;
            o_misaligned <= 1'b0;
            pend_vld     <= 1'b0;
            pend_addr    <= '0;
        end else begin
            o_address    <= address_nxt;
            o_epc        <= epc_nxt;
            o_redirect   <= redirect_nxt;
            o_misaligned <= misaligned_nxt;
            pend_vld     <= pend_vld_nxt;
            pend_addr    <= pend_addr_nxt;
        end
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program counter for the MIPS fetch stage; successor to the fixed 32-bit free-running PC.
- Adds a configurable reset vector, exception vector and alignment.
- Adds jump/branch redirect with fixed priority, a stall hold, and a one-entry pending-redirect buffer so a redirect raised during a stall is not lost.
- Feeds instruction memory address and the IF/ID pipeline register.

Parameters:
WIDTH, 32, address width in bits
ALIGN, 2, number of low address bits forced to zero; increment = 2**ALIGN
RESET_ADDR, 32'h0000_0000, address loaded on reset (low ALIGN bits ignored)
EXC_ADDR, 32'h8000_0180, exception vector (low ALIGN bits ignored)

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst  input  1  synchronous reset, active-high
i_stall  input  1  hold current address (hazard stall)
i_jump_en  input  1  jump redirect request
i_jump_target  input  WIDTH  jump target
i_branch_en  input  1  taken-branch redirect request
i_branch_target  input  WIDTH  branch target
i_exc  input  1  exception request
o_address  output  WIDTH  current fetch address
o_next_seq  output  WIDTH  o_address + 2**ALIGN (combinational, for link register)
o_epc  output  WIDTH  address held in o_address when the last exception was taken
o_redirect  output  1  high for the cycle in which o_address holds a non-sequential value
o_misaligned  output  1  one-cycle pulse when a loaded target had nonzero low ALIGN bits

Behaviour:
- Reset is sampled only on the i_clk rising edge. While i_rst=1, all requests are ignored.
  - o_address=RESET_ADDR with the low ALIGN bits cleared.
  - o_epc=0, o_redirect=0, o_misaligned=0.
  - Pending buffer cleared: pend_vld=0, pend_addr=0.
- Reset in the middle of a stall or with a pending redirect discards everything; reset wins over all inputs.
- Target selection within one cycle: jump over branch. Selected target is sel_t.
- Next-state priority, highest first:
  1. i_exc=1:
     - o_address <= EXC_ADDR with low bits cleared; o_epc <= o_address.
     - pend_vld <= 0; o_redirect <= 1.
     - Applies even when i_stall=1. Same-cycle jump or branch is dropped.
  2. i_stall=1:
     - o_address holds; o_redirect <= 0.
     - If jump or branch is asserted: pend_vld <= 1, pend_addr <= sel_t. A newer request overwrites an older pending one.
  3. Jump or branch asserted, no stall:
     - o_address <= sel_t; o_redirect <= 1; pend_vld <= 0.
     - The current request takes precedence over a stale pending one.
  4. pend_vld=1, no stall:
     - o_address <= pend_addr; o_redirect <= 1; pend_vld <= 0.
  5. Otherwise:
     - o_address <= o_address + 2**ALIGN, modulo 2**WIDTH (wraps to 0); o_redirect <= 0.
- Loaded targets (sel_t, pend_addr, vectors) always have the low ALIGN bits forced to 0.
- o_misaligned <= 1 for one cycle when a jump, branch or pending target is loaded into o_address with nonzero original low bits. Vectors never flag. pend_addr retains the original low bits so the flag can be computed at load time.
- o_address low ALIGN bits are always 0.
- Latency: a request at edge N is visible on o_address after edge N, one cycle. A redirect raised during a stall is visible one cycle after the stall drops.

Test Plan:
- Reset then run: hold i_rst=1 for 2 cycles, release -> o_address=0x0, then 0x4, 0x8, 0xC on successive edges; o_next_seq=o_address+4.
- Simultaneous redirects: i_jump_en=1 target 0x100 and i_branch_en=1 target 0x200 in the same cycle -> o_address=0x100, o_redirect=1 for one cycle, then 0x104 with o_redirect=0.
- Stall with overwritten pending redirect:
  - From 0x40, i_stall=1 for 3 cycles; branch to 0x80 in stall cycle 1, jump to 0x90 in stall cycle 2 -> o_address stays 0x40.
  - After the stall drops: 0x90, then 0x94.
- Exception during stall:
  - At 0x40 with a pending redirect, assert i_exc with i_stall=1 -> o_address=0x80000180, o_epc=0x40, o_redirect=1.
  - Next cycle 0x80000184; the pending redirect is never applied.
- Wrap and misalignment:
  - WIDTH=32 at 0xFFFFFFFC, no requests -> 0x0.
  - Jump to 0x103 -> o_address=0x100, o_misaligned=1 for exactly one cycle.
- Reset mid-operation: assert i_rst during a stall with pend_vld=1 -> o_address=RESET_ADDR, then sequential increment; no redirect pulse after release.
